// File: rtl/rv_alu_pkg.sv
// Shared constants for the sequential RV32I/RV-M execute unit:
// funct3 one-hot bit positions, M-op indices and the handshake FSM states.
package rv_alu_pkg;

  localparam int XLEN_DEF = 32;

  localparam int F3_ADD  = 0;
  localparam int F3_SLL  = 1;
  localparam int F3_SLT  = 2;
  localparam int F3_SLTU = 3;
  localparam int F3_XOR  = 4;
  localparam int F3_SR   = 5;
  localparam int F3_OR   = 6;
  localparam int F3_AND  = 7;

  // Branch compares reuse the same one-hot funct3 vector
  localparam int F3_BEQ  = 0;
  localparam int F3_BNE  = 1;
  localparam int F3_BLT  = 4;
  localparam int F3_BGE  = 5;
  localparam int F3_BLTU = 6;
  localparam int F3_BGEU = 7;

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV-M engine: radix-2 shift-add multiply and restoring divide on
// magnitudes, one bit per cycle, with the sign applied when done is raised.
module mdu_iter
  import rv_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   count;
  logic            active;
  logic [2:0]      op_q;
  logic            neg_q;
  logic            rneg_q;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] opnd;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [2*XLEN-1:0] product;

  assign a_neg = a[XLEN-1] & (op == M_MUL || op == M_MULH || op == M_MULHSU ||
                              op == M_DIV || op == M_REM);
  assign b_neg = b[XLEN-1] & (op == M_MUL || op == M_MULH || op == M_DIV || op == M_REM);
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;

  assign mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc, quo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  assign product = neg_q ? -{acc, quo} : {acc, quo};
  assign done    = active && (count == '0);

  always_comb begin
    result = '0;
    if (!op_q[2])
      result = (op_q == M_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    else if (op_q[1])
      result = rneg_q ? -acc : acc;
    else
      result = neg_q ? -quo : quo;
  end

  // Multiply: acc:quo shifts right with the multiplier in quo. Divide: quo
  // shifts the dividend out of the top while quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      count  <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      acc    <= '0;
      quo    <= '0;
      opnd   <= '0;
    end else if (flush) begin
      active <= 1'b0;
      count  <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= CW'(XLEN);
      op_q   <= op;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      acc    <= '0;
      quo    <= op[2] ? a_abs : b_abs;
      opnd   <= op[2] ? b_abs : a_abs;
    end else if (active) begin
      if (count != '0) begin
        count <= count - 1'b1;
        if (!op_q[2]) begin
          acc <= mul_sum[XLEN:1];
          quo <= {mul_sum[0], quo[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
          acc <= div_diff[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b1};
        end else begin
          acc <= div_shift[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b0};
        end
      end else begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// Execute-stage integer unit: registered single-cycle ALU, iterative RV-M
// engine behind a valid/ready handshake, and a combinational branch compare.
module alu_mdu_seq
  import rv_alu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int SHW    = $clog2(XLEN),
  parameter int MUL_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            isALUimm,
  input  logic            isALUreg,
  input  logic            isMulDiv,
  input  logic            isBranch,
  input  logic [7:0]      funct3oh,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            correct,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic            accept;
  logic            lt, ltu, eq;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [2:0]      m_idx;
  logic            div_zero, div_ovf, iter_go;
  logic [XLEN-1:0] fast_res;
  logic            mdu_start, mdu_done;
  logic [XLEN-1:0] mdu_result;

  assign in_ready = (state == IDLE) || (state == HOLD && out_ready);
  assign accept   = in_valid && in_ready;

  assign eq    = (rs1 == rs2);
  assign lt    = ($signed(rs1) < $signed(rs2));
  assign ltu   = (rs1 < rs2);
  assign shamt = rs2[SHW-1:0];

  assign correct = (funct3oh[F3_BEQ]  &  eq)  | (funct3oh[F3_BNE]  & ~eq)  |
                   (funct3oh[F3_BLT]  &  lt)  | (funct3oh[F3_BGE]  & ~lt)  |
                   (funct3oh[F3_BLTU] &  ltu) | (funct3oh[F3_BGEU] & ~ltu);

  always_comb begin
    alu_res = '0;
    if (funct3oh[F3_ADD])  alu_res = (isALUreg && funct7_5) ? rs1 - rs2 : rs1 + rs2;
    if (funct3oh[F3_SLL])  alu_res = rs1 << shamt;
    if (funct3oh[F3_SLT])  alu_res = {{(XLEN-1){1'b0}}, lt};
    if (funct3oh[F3_SLTU]) alu_res = {{(XLEN-1){1'b0}}, ltu};
    if (funct3oh[F3_XOR])  alu_res = rs1 ^ rs2;
    if (funct3oh[F3_SR])   alu_res = funct7_5 ? XLEN'($signed(rs1) >>> shamt) : rs1 >> shamt;
    if (funct3oh[F3_OR])   alu_res = rs1 | rs2;
    if (funct3oh[F3_AND])  alu_res = rs1 & rs2;
  end

  // Divide corner cases resolve in one cycle like ordinary ALU ops
  assign m_idx    = oh_to_idx(funct3oh);
  assign div_zero = m_idx[2] && (rs2 == '0);
  assign div_ovf  = m_idx[2] && !m_idx[0] && (rs1 == SMIN) && (rs2 == '1);
  assign iter_go  = isMulDiv && (MUL_EN != 0) && !div_zero && !div_ovf;

  always_comb begin
    fast_res = '0;
    if (isMulDiv) begin
      if (MUL_EN != 0 && div_zero)     fast_res = m_idx[1] ? rs1 : '1;
      else if (MUL_EN != 0 && div_ovf) fast_res = m_idx[1] ? '0 : SMIN;
    end else if ((isALUreg || isALUimm) && !isBranch) begin
      fast_res = alu_res;
    end
  end

  assign mdu_start = accept && iter_go && !flush;

  if (MUL_EN != 0) begin : g_mdu
    mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .start  (mdu_start),
      .op     (m_idx),
      .a      (rs1),
      .b      (rs2),
      .done   (mdu_done),
      .result (mdu_result)
    );
  end else begin : g_no_mdu
    assign mdu_done   = 1'b0;
    assign mdu_result = '0;
  end

  // out_valid is high exactly while in HOLD; a HOLD-state accept pipelines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (iter_go) begin
              state     <= CALC;
              busy      <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
              result    <= fast_res;
            end
          end else if (state == HOLD && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        CALC: begin
          if (mdu_done) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            result    <= mdu_result;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed-vector bench for alu_mdu_seq with hand-computed expectations;
// inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        isALUimm, isALUreg, isMulDiv, isBranch, funct7_5;
  logic [7:0]  funct3oh;
  logic [31:0] rs1, rs2, result;
  logic        in_ready, correct, out_valid, busy;

  int checks = 0;
  int errors = 0;
  int cycles;
  bit ready_seen;
  bit valid_seen;

  always #5 clk = ~clk;

  alu_mdu_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .isALUimm  (isALUimm),
    .isALUreg  (isALUreg),
    .isMulDiv  (isMulDiv),
    .isBranch  (isBranch),
    .funct3oh  (funct3oh),
    .funct7_5  (funct7_5),
    .rs1       (rs1),
    .rs2       (rs2),
    .correct   (correct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // cls: 0 = OP, 1 = OP-IMM, 2 = RV-M; presents the op for exactly one edge
  task automatic applyStimulus(input int cls, input int f3, input logic f75,
                               input logic [31:0] a, input logic [31:0] b);
    isALUreg = (cls == 0);
    isALUimm = (cls == 1);
    isMulDiv = (cls == 2);
    isBranch = 1'b0;
    funct3oh = 8'(1 << f3);
    funct7_5 = f75;
    rs1      = a;
    rs2      = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitForResult(output int n, output bit saw_ready);
    n = 0;
    saw_ready = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) saw_ready = 1'b1;
      tick();
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    isALUimm = 1'b0; isALUreg = 1'b0; isMulDiv = 1'b0; isBranch = 1'b0;
    funct7_5 = 1'b0; funct3oh = 8'h00; rs1 = '0; rs2 = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    applyStimulus(0, 0, 1'b0, 32'd5, 32'hFFFF_FFFD);
    checkOutput("add_valid", out_valid, 1);
    checkOutput("add_result", result, 32'd2);
    checkOutput("add_in_ready", in_ready, 1);
    applyStimulus(0, 0, 1'b1, 32'd5, 32'd7);
    checkOutput("sub_valid", out_valid, 1);
    checkOutput("sub_result", result, 32'hFFFF_FFFE);
    tick();
    checkOutput("drain_valid", out_valid, 0);

    applyStimulus(0, 5, 1'b1, 32'h8000_0000, 32'h21);
    checkOutput("sra_result", result, 32'hC000_0000);
    applyStimulus(1, 5, 1'b0, 32'h8000_0000, 32'h21);
    checkOutput("srli_result", result, 32'h4000_0000);
    applyStimulus(0, 3, 1'b0, 32'd1, 32'hFFFF_FFFF);
    checkOutput("sltu_result", result, 32'd1);
    applyStimulus(0, 2, 1'b0, 32'd1, 32'hFFFF_FFFF);
    checkOutput("slt_result", result, 32'd0);
    applyStimulus(1, 0, 1'b1, 32'd5, 32'd7);
    checkOutput("addi_ignores_f7", result, 32'd12);

    applyStimulus(2, 3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("mulhu_busy", busy, 1);
    waitForResult(cycles, ready_seen);
    checkOutput("mulhu_latency", cycles, 33);
    checkOutput("mulhu_ready_low", ready_seen, 0);
    checkOutput("mulhu_result", result, 32'hFFFF_FFFE);
    checkOutput("mulhu_busy_done", busy, 0);
    applyStimulus(2, 0, 1'b0, 32'hFFFF_FFF9, 32'd3);
    waitForResult(cycles, ready_seen);
    checkOutput("mul_result", result, 32'hFFFF_FFEB);
    applyStimulus(2, 1, 1'b0, 32'hFFFF_FFF9, 32'd3);
    waitForResult(cycles, ready_seen);
    checkOutput("mulh_result", result, 32'hFFFF_FFFF);
    applyStimulus(2, 4, 1'b0, 32'hFFFF_FFEC, 32'd3);
    waitForResult(cycles, ready_seen);
    checkOutput("div_latency", cycles, 33);
    checkOutput("div_result", result, 32'hFFFF_FFFA);
    applyStimulus(2, 6, 1'b0, 32'hFFFF_FFEC, 32'd3);
    waitForResult(cycles, ready_seen);
    checkOutput("rem_result", result, 32'hFFFF_FFFE);

    applyStimulus(2, 4, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div_ovf_valid", out_valid, 1);
    checkOutput("div_ovf_result", result, 32'h8000_0000);
    applyStimulus(2, 6, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("rem_ovf_result", result, 32'd0);
    applyStimulus(2, 5, 1'b0, 32'd10, 32'd0);
    checkOutput("divu_zero_result", result, 32'hFFFF_FFFF);
    applyStimulus(2, 7, 1'b0, 32'd10, 32'd0);
    checkOutput("remu_zero_valid", out_valid, 1);
    checkOutput("remu_zero_result", result, 32'd10);
    tick();

    out_ready = 1'b0;
    applyStimulus(0, 0, 1'b0, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_result", result, 32'd2);
      checkOutput("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    checkOutput("hold_release", out_valid, 0);

    applyStimulus(2, 4, 1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_in_ready", in_ready, 1);
    checkOutput("flush_valid", out_valid, 0);
    valid_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) valid_seen = 1'b1;
      tick();
    end
    checkOutput("flush_no_valid", valid_seen, 0);

    isMulDiv = 1'b0;
    isBranch = 1'b1;
    rs1 = 32'hFFFF_FFFF;
    rs2 = 32'd1;
    funct3oh = 8'b0001_0000;
    #1 checkOutput("blt_taken", correct, 1);
    funct3oh = 8'b0100_0000;
    #1 checkOutput("bltu_not_taken", correct, 0);
    funct3oh = 8'b1000_0000;
    #1 checkOutput("bgeu_taken", correct, 1);
    funct3oh = 8'b0000_0010;
    rs2 = 32'hFFFF_FFFF;
    #1 checkOutput("bne_equal", correct, 0);
    tick();

    applyStimulus(2, 0, 1'b0, 32'd6, 32'd7);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", out_valid, 0);
    checkOutput("async_rst_result", result, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(0, 4, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    checkOutput("post_reset_xor", result, 32'hFF00_FF00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised successor to the RV32I combinational ALU.
- Registers single-cycle integer ops and adds an iterative RV-M multiply/divide engine behind a valid/ready handshake.
- Sits in execute stage between decode (one-hot funct3) and writeback; stalls front end via in_ready while an M op iterates.
- Branch compare (`correct`) stays combinational for same-cycle redirect.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- SHW, $clog2(XLEN), shift-amount bits taken from rs2.
- MUL_EN, 1, 0 removes M engine; M ops then return 0 with latency 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any in-flight op
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts operation this cycle
- isALUimm  in  1  OP-IMM class
- isALUreg  in  1  OP class
- isMulDiv  in  1  OP with funct7=0000001 (RV-M)
- isBranch  in  1  branch compare class
- funct3oh  in  8  one-hot funct3
- funct7_5  in  1  funct7 bit 5 (SUB/SRA select)
- rs1  in  XLEN  operand A
- rs2  in  XLEN  operand B or immediate
- correct  out  1  combinational branch-taken, RV32I encoding semantics (BEQ/BNE/BLT/BGE/BLTU/BGEU)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- busy  out  1  M engine iterating

Behaviour:
- Reset: state IDLE, out_valid=0, result=0, busy=0, in_ready=1, internal acc/quotient/counter=0.
- States:
  - IDLE: accept.
  - CALC: M iteration.
  - HOLD: out_valid=1, waiting on out_ready.
- Handshakes:
  - in_ready = (IDLE) | (HOLD & out_ready). Accept = in_valid & in_ready.
  - Non-M accept: result registered next edge; out_valid=1 one cycle after accept (latency 1). State → HOLD if !out_ready at that time, else stays pipelined (back-to-back throughput 1/cycle).
  - M accept: → CALC, busy=1, counter=XLEN.
    - MUL/MULH/MULHSU/MULHU: radix-2 shift-add on absolute values, sign fixed at end; XLEN+1 cycles to out_valid.
    - DIV/DIVU/REM/REMU: restoring divide; XLEN+1 cycles to out_valid.
    - Counter hits 0 → HOLD, busy=0.
  - HOLD: result and out_valid stable until out_ready=1; then out_valid drops unless a new non-M op is accepted the same cycle.
- Arithmetic:
  - All ops modulo 2^XLEN.
  - Shifts use rs2[SHW-1:0] only; SRA sign-fills.
  - SLT signed, SLTU unsigned, result 0/1 zero-extended.
  - Invalid/unlisted op class → result 0.
- Divide corner cases (RISC-V spec):
  - Divide by zero: quotient all-ones, remainder = rs1.
  - Signed overflow (min / -1): quotient = min, remainder = 0.
  - Both corner cases complete in 1 cycle (skip CALC).
- Simultaneous events:
  - flush wins over everything: state → IDLE, out_valid=0, busy=0 next edge, and any same-cycle accept is discarded.
  - in_valid during CALC is ignored (in_ready=0); upstream must hold.
  - Async reset mid-CALC returns all outputs to reset values immediately.
- `correct` depends only on rs1/rs2/funct3oh; it is not gated by handshake.

Decomposition:
- Shared package `rv_alu_pkg`:
  - funct3 one-hot bit indices (F3_ADD..F3_AND).
  - M-op index constants.
  - State enum (IDLE/CALC/HOLD).
  - XLEN default.
- One sub-module, `mdu_iter`: the iterative mul/div datapath with start/done, sized by XLEN. The top keeps the single-cycle ALU, branch compare, and FSM/handshake.

Test Plan:
- ADD 5+(-3), out_ready=1 → out_valid one cycle later, result=2; back-to-back SUB 5-7 next cycle → result=0xFFFFFFFE on following cycle.
- SRA rs1=0x80000000, rs2=0x21 (shamt 1) → 0xC0000000; SLTU 1 vs 0xFFFFFFFF → 1; SLT same → 0.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → in_ready=0 for 33 cycles, result=0xFFFFFFFE; MUL -7×3 → 0xFFFFFFEB.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, 1-cycle latency; DIVU 10/0 → 0xFFFFFFFF, REMU 10/0 → 10.
- out_ready held 0 for 5 cycles after result → result/out_valid stable, in_ready=0; flush mid-DIV (cycle 10) → out_valid never asserts, busy=0, in_ready=1 next cycle.
- Branch: BLT rs1=-1, rs2=1 → correct=1; BLTU same operands → correct=0; assert rst_n=0 mid-CALC → out_valid=0, result=0 immediately.
